// File: rtl/sum_accumulator.sv
// Accumulates a counted run of unsigned adder results into a running total,
// tracking the largest and smallest accepted sample; all outputs registered.
module sum_accumulator #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8,
    parameter int SUM_W  = DATA_W + CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [CNT_W-1:0]  COUNT,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_SUM,
    output logic              IN_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic [SUM_W-1:0]  SUM_OUT,
    output logic [DATA_W-1:0] MAX_OUT,
    output logic [DATA_W-1:0] MIN_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    remaining_r;
    logic [SUM_W-1:0]    sum_r;
    logic [DATA_W-1:0]   max_r;
    logic [DATA_W-1:0]   min_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic                start_s;
    logic                accept_s;

    // ready_r mirrors state_r == ST_ACCUM, so it doubles as the accept qualifier
    assign start_s  = (state_r == ST_IDLE) && START;
    assign accept_s = ready_r && IN_VALID;

    assign IN_READY = ready_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign SUM_OUT  = sum_r;
    assign MAX_OUT  = max_r;
    assign MIN_OUT  = min_r;

    // Next-state logic for the run sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_s = (COUNT != CNT_ZERO) ? ST_ACCUM : ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && (remaining_r == CNT_ONE)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags are decoded from the next state so they line up with state_r
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_ACCUM);
            busy_r  <= (state_s == ST_ACCUM) || (state_s == ST_DONE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Datapath: remaining count, running total and extrema
    always_ff @(posedge CLK) begin
        if (RST) begin
            remaining_r <= CNT_ZERO;
            sum_r       <= {SUM_W{1'b0}};
            max_r       <= {DATA_W{1'b0}};
            min_r       <= {DATA_W{1'b1}};
        end else if (start_s) begin
            remaining_r <= COUNT;
            sum_r       <= {SUM_W{1'b0}};
            max_r       <= {DATA_W{1'b0}};
            min_r       <= {DATA_W{1'b1}};
        end else if (accept_s) begin
            remaining_r <= remaining_r - CNT_ONE;
            sum_r       <= sum_r + {{(SUM_W-DATA_W){1'b0}}, IN_SUM};
            max_r       <= (IN_SUM > max_r) ? IN_SUM : max_r;
            min_r       <= (IN_SUM < min_r) ? IN_SUM : min_r;
        end else begin
            remaining_r <= remaining_r;
            sum_r       <= sum_r;
            max_r       <= max_r;
            min_r       <= min_r;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized and directed runs of sum_accumulator checked against a
// transaction-level model: the list of accepted samples folded into sum/max/min.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] count;
    logic       in_valid;
    logic [5:0] in_sum;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [13:0] sum_out;
    logic [5:0] max_out;
    logic [5:0] min_out;

    int checks = 0;
    int errors = 0;
    int vq[$];
    int dq[$];

    sum_accumulator #(.DATA_W(6), .CNT_W(8), .SUM_W(14)) dut (
        .CLK(clk), .RST(rst), .START(start), .COUNT(count),
        .IN_VALID(in_valid), .IN_SUM(in_sum), .IN_READY(in_ready),
        .BUSY(busy), .DONE(done), .SUM_OUT(sum_out),
        .MAX_OUT(max_out), .MIN_OUT(min_out)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input int s, input int mx, input int mn);
        check_value({tag, "_sum"}, int'(sum_out), s);
        check_value({tag, "_max"}, int'(max_out), mx);
        check_value({tag, "_min"}, int'(min_out), mn);
    endtask

    // mode 0: random valid/data, mode 1: valid every cycle with fixed_val, mode 2: vq/dq tables
    task automatic run(input int cnt, input int mode, input int fixed_val, input bit hold_start);
        int acc[$];
        int n, cyc, v, d, s, mx, mn;
        @(negedge clk);
        start = 1'b1;
        count = 8'(cnt);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        if (hold_start) count = 8'(cnt + 5);
        else start = 1'b0;
        @(negedge clk);
        if (cnt != 0) begin
            check_value("busy_after_start", int'(busy), 1);
            n = 0;
            cyc = 0;
            while (n < cnt && cyc < 4000) begin
                check_value("ready_in_run", int'(in_ready), 1);
                check_value("no_early_done", int'(done), 0);
                if (mode == 1) begin
                    v = 1; d = fixed_val;
                end else if (mode == 2) begin
                    v = (vq.size() > 0) ? vq.pop_front() : 0;
                    d = (dq.size() > 0) ? dq.pop_front() : 0;
                end else begin
                    v = ($urandom_range(3, 0) != 0) ? 1 : 0;
                    d = int'($urandom_range(63, 0));
                end
                in_valid = v[0];
                in_sum = 6'(d);
                @(posedge clk);
                if (v != 0) begin
                    acc.push_back(d);
                    n++;
                end
                cyc++;
                @(negedge clk);
            end
        end
        s = 0; mx = 0; mn = 63;
        foreach (acc[i]) begin
            s += acc[i];
            if (acc[i] > mx) mx = acc[i];
            if (acc[i] < mn) mn = acc[i];
        end
        check_value("done_pulse", int'(done), 1);
        check_value("busy_in_done", int'(busy), 1);
        check_value("ready_in_done", int'(in_ready), 0);
        check_results("final", s, mx, mn);
        // a sample offered in DONE and IDLE must not disturb the held results
        in_valid = 1'b1;
        in_sum = 6'($urandom_range(63, 0));
        @(negedge clk);
        check_value("done_one_cycle", int'(done), 0);
        check_value("idle_busy", int'(busy), 0);
        check_value("idle_ready", int'(in_ready), 0);
        check_results("held", s, mx, mn);
        if (hold_start) begin
            in_valid = 1'b0;
            @(negedge clk);
            check_value("restart_in_idle_busy", int'(busy), 1);
            check_value("restart_in_idle_ready", int'(in_ready), 1);
            check_results("restart_cleared", 0, 0, 63);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_value("cleanup_busy", int'(busy), 0);
        end else begin
            @(negedge clk);
            check_results("idle_valid_ignored", s, mx, mn);
            check_value("idle_still_idle", int'(busy), 0);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = 8'd0; in_valid = 1'b0; in_sum = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_done", int'(done), 0);
        check_value("rst_busy", int'(busy), 0);
        check_value("rst_ready", int'(in_ready), 0);
        check_results("rst", 0, 0, 63);
        rst = 1'b0;

        vq = '{1, 1, 1, 1};
        dq = '{3, 30, 0, 17};
        run(4, 2, 0, 1'b0);

        vq = '{1, 0, 0, 1, 0, 1};
        dq = '{5, 9, 9, 7, 9, 2};
        run(3, 2, 0, 1'b0);

        run(255, 1, 30, 1'b0);
        check_value("full_scale_30", int'(sum_out), 7650);
        run(255, 1, 63, 1'b0);
        check_value("full_scale_63", int'(sum_out), 16065);

        run(0, 0, 0, 1'b0);

        // reset in the middle of an 8-sample run, with a start and a sample on the same edge
        @(negedge clk);
        start = 1'b1; count = 8'd8;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum = 6'(20 + k);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_sum = 6'd40;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_value("abort_done", int'(done), 0);
        check_value("abort_busy", int'(busy), 0);
        check_value("abort_ready", int'(in_ready), 0);
        check_results("abort", 0, 0, 63);
        @(negedge clk);
        check_value("abort_no_done_later", int'(done), 0);
        vq = '{1};
        dq = '{12};
        run(1, 2, 0, 1'b0);

        run(2, 0, 0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            run(int'($urandom_range(20, 0)), 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, giving the width of each incoming adder result.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the sample-count field.
REQ-003 The block SHALL have parameter SUM_W, default DATA_W+CNT_W (14), giving the accumulator width.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port RST, input, 1, the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port START, input, 1, a request to begin a new accumulation run.
REQ-007 The block SHALL have port COUNT, input, CNT_W, the number of samples for the run, sampled with START.
REQ-008 The block SHALL have port IN_VALID, input, 1, which qualifies IN_SUM.
REQ-009 The block SHALL have port IN_SUM, input, DATA_W, the unsigned adder result (upstream adder OUT).
REQ-010 The block SHALL have port IN_READY, output, 1, which is high when a sample can be accepted.
REQ-011 The block SHALL have port BUSY, output, 1, which is high while a run is in progress (ACCUM or DONE state).
REQ-012 The block SHALL have port DONE, output, 1, a one-cycle pulse marking run completion.
REQ-013 The block SHALL have port SUM_OUT, output, SUM_W, the unsigned total of the accepted samples.
REQ-014 The block SHALL have port MAX_OUT, output, DATA_W, the largest accepted sample.
REQ-015 The block SHALL have port MIN_OUT, output, DATA_W, the smallest accepted sample.

Function
REQ-016 The block SHALL be a three-state FSM with states IDLE, ACCUM and DONE, and all outputs registered.
REQ-017 In IDLE, START=1 SHALL latch COUNT into a remaining-count register; it SHALL also set SUM_OUT=0, MAX_OUT=0 and MIN_OUT=all ones.
REQ-018 In IDLE, START=1 SHALL move the FSM to ACCUM if COUNT!=0, and to DONE if COUNT==0.
REQ-019 START SHALL be ignored in the ACCUM and DONE states.
REQ-020 IN_READY SHALL be 1 exactly when the state is ACCUM.
REQ-021 A sample SHALL be accepted on an edge where IN_READY=1 and IN_VALID=1; there is no limit on IN_VALID gaps.
REQ-022 On each accepted sample, the block SHALL update SUM_OUT to SUM_OUT+IN_SUM, and this SHALL never overflow, since (2^CNT_W-1)*(2^DATA_W-1) < 2^SUM_W.
REQ-023 On each accepted sample, MAX_OUT SHALL become max(MAX_OUT,IN_SUM), MIN_OUT SHALL become min(MIN_OUT,IN_SUM), and the remaining count SHALL decrement by 1.
REQ-024 The accept that brings the remaining count from 1 to 0 SHALL move the FSM to DONE; the sample on that edge SHALL be included in the results.
REQ-025 In DONE, DONE SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-026 DONE SHALL rise on the edge immediately after the final accept (latency 1 cycle).
REQ-027 SUM_OUT, MAX_OUT and MIN_OUT SHALL hold final values from the DONE cycle until the next accepted START or RST.
REQ-028 A COUNT=0 run SHALL produce DONE one cycle after START, with SUM_OUT=0, MAX_OUT=0 and MIN_OUT=all ones.
REQ-029 A START asserted in the DONE cycle SHALL be ignored; back-to-back runs therefore need START on or after the first IDLE cycle.
REQ-030 IN_VALID=1 outside ACCUM SHALL have no effect on any state or output.

Reset
REQ-031 RST=1 at an edge SHALL force IDLE and SHALL set DONE=0, BUSY=0, IN_READY=0, SUM_OUT=0, MAX_OUT=0, MIN_OUT=all ones, and the remaining count to 0.
REQ-032 RST SHALL have priority over START and over a sample accept on the same edge.
REQ-033 RST asserted mid-run SHALL abort the run, with no DONE pulse and partial results discarded.

Verification
REQ-034 The bench SHALL cover a basic run: COUNT=4 with samples 3,30,0,17 -> DONE one cycle after the 4th accept, with SUM_OUT=50, MAX_OUT=30, MIN_OUT=0.
REQ-035 The bench SHALL cover a gapped-valid run: COUNT=3 with IN_VALID toggling 1,0,0,1,0,1 and data 5,9,9,7,9,2 -> only 5,7,2 accepted; SUM_OUT=14, MAX_OUT=7, MIN_OUT=2.
REQ-036 The bench SHALL cover a full-scale run: COUNT=255 with each sample 30 (the maximum 4-bit adder sum, 15+15) -> SUM_OUT=7650, no wrap; then COUNT=255 with each sample 63 -> SUM_OUT=16065.
REQ-037 The bench SHALL cover a zero count: COUNT=0 START -> DONE pulse next cycle, IN_READY never high, SUM_OUT=0, MIN_OUT=63.
REQ-038 The bench SHALL cover a reset mid-run: COUNT=8, RST after 3 accepts -> next cycle IDLE with all outputs at reset values; a subsequent COUNT=1 run with sample 12 -> SUM_OUT=12, MAX_OUT=12, MIN_OUT=12.
REQ-039 The bench SHALL cover ignored START: START held high through ACCUM and DONE of a COUNT=2 run -> COUNT is not reloaded mid-run; a new run begins only in IDLE.
